// File: rtl/free_list.sv
`timescale 1ns/1ps
// free_list: circular FIFO of free physical-register tags for a 2-wide rename stage.
// Latency: fl_pr0/fl_pr1/fl_avail_num/fl_count are combinational from registered state; fl_error is registered (one cycle).
// Backpressure: dispatch may take at most fl_avail_num tags. Excess requests are clamped, as are returns that would overfill the list, and either one pulses fl_error.
//
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   id_dispatch_num       - tags requested by dispatch this cycle (0..2)
//   rob_retire_num        - Told tags returned by retirement this cycle (0..2)
//   rob_retire_told0/1    - returned tags, told0 is the older instruction
//   rob_flush             - squash: recover every tag held by un-retired instructions
//   fl_pr0/fl_pr1         - next free tags, valid up to fl_avail_num
//   fl_avail_num          - min(count, 2)
//   fl_count              - number of free tags held (0..DEPTH)
//   fl_error              - one-cycle pulse after an underflow or overflow attempt
module free_list #(
  parameter int NUM_PR = 64,
  parameter int NUM_AR = 32,
  parameter int DEPTH  = NUM_PR - NUM_AR,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       id_dispatch_num,
  input  logic [1:0]       rob_retire_num,
  input  logic [6:0]       rob_retire_told0,
  input  logic [6:0]       rob_retire_told1,
  input  logic             rob_flush,
  output logic [6:0]       fl_pr0,
  output logic [6:0]       fl_pr1,
  output logic [1:0]       fl_avail_num,
  output logic [PTR_W:0]   fl_count,
  output logic             fl_error
);

  localparam int CW = PTR_W + 1;

  logic [6:0]       entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CW-1:0]    count;
  logic             error_q;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_next;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    held;
  logic [CW-1:0]    space;
  logic [1:0]       avail;
  logic [1:0]       alloc;
  logic [1:0]       req_rel;
  logic [1:0]       rel;
  logic             disp_err;
  logic             ovf_err;

  // DEPTH is a power of two, so natural PTR_W-bit overflow is the modulo wrap.
  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  always_comb begin
    avail      = (count >= CW'(2)) ? 2'd2 : count[1:0];
    req_rel    = (rob_retire_num == 2'd3) ? 2'd2 : rob_retire_num;
    alloc      = 2'd0;
    disp_err   = 1'b0;
    rel        = req_rel;
    ovf_err    = 1'b0;

    // Flush redirects head, so a dispatch request in that cycle takes nothing.
    if (!rob_flush) begin
      disp_err = (id_dispatch_num > avail);
      alloc    = disp_err ? avail : id_dispatch_num;
    end

    // Room for returns is judged after this cycle's allocation leaves; only
    // as many returns as fit are written, the rest are dropped.
    held  = count - CW'(alloc);
    space = CW'(DEPTH) - held;
    if (space < CW'(req_rel)) begin
      rel     = space[1:0];
      ovf_err = 1'b1;
    end

    tail_next  = tail + PTR_W'(rel);
    // On flush the slots between the new tail and the old head hold exactly the
    // tags of squashed instructions in dispatch order, so rewinding head to the
    // tail recovers all of them.
    head_next  = rob_flush ? tail_next : head + PTR_W'(alloc);
    count_next = rob_flush ? CW'(DEPTH) : held + CW'(rel);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= 7'(NUM_AR + i);
      end
      head    <= '0;
      tail    <= '0;
      count   <= CW'(DEPTH);
      error_q <= 1'b0;
    end else begin
      if (rel != 2'd0) begin
        entries[tail] <= rob_retire_told0;
      end
      if (rel == 2'd2) begin
        entries[tail_p1] <= rob_retire_told1;
      end
      head    <= head_next;
      tail    <= tail_next;
      count   <= count_next;
      error_q <= disp_err | ovf_err;
    end
  end

  // Released tags are never bypassed: they show up only once head reaches them.
  assign fl_pr0       = entries[head];
  assign fl_pr1       = entries[head_p1];
  assign fl_avail_num = avail;
  assign fl_count     = count;
  assign fl_error     = error_q;

endmodule

// File: tb/tb_free_list.sv
`timescale 1ns/1ps
// tb_free_list: directed self-checking bench for the rename free list.
// Latency: inputs change and outputs are sampled 1ns after each rising edge.
// Backpressure: none, the bench drives dispatch/retire counts directly.
module tb_free_list;

  logic       clock;
  logic       reset;
  logic [1:0] id_dispatch_num;
  logic [1:0] rob_retire_num;
  logic [6:0] rob_retire_told0;
  logic [6:0] rob_retire_told1;
  logic       rob_flush;
  logic [6:0] fl_pr0;
  logic [6:0] fl_pr1;
  logic [1:0] fl_avail_num;
  logic [5:0] fl_count;
  logic       fl_error;

  int n_checks = 0;
  int n_errors = 0;

  free_list dut (
    .clock            (clock),
    .reset            (reset),
    .id_dispatch_num  (id_dispatch_num),
    .rob_retire_num   (rob_retire_num),
    .rob_retire_told0 (rob_retire_told0),
    .rob_retire_told1 (rob_retire_told1),
    .rob_flush        (rob_flush),
    .fl_pr0           (fl_pr0),
    .fl_pr1           (fl_pr1),
    .fl_avail_num     (fl_avail_num),
    .fl_count         (fl_count),
    .fl_error         (fl_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Expected allocation order after the flush scenario: slots 2..31 still hold
  // the reset image 34..63, then slots 0 and 1 hold the retired tags 3 and 4.
  function automatic int flush_seq(input int i);
    if (i < 30) return 34 + i;
    else if (i == 30) return 3;
    else return 4;
  endfunction

  initial begin
    int e0;

    reset            = 1'b1;
    id_dispatch_num  = 2'd0;
    rob_retire_num   = 2'd0;
    rob_retire_told0 = 7'd0;
    rob_retire_told1 = 7'd0;
    rob_flush        = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset image.
    check("rst_pr0",   fl_pr0, 32);
    check("rst_pr1",   fl_pr1, 33);
    check("rst_avail", fl_avail_num, 2);
    check("rst_count", fl_count, 32);
    check("rst_err",   fl_error, 0);

    // Drain the list two at a time.
    for (int k = 0; k < 16; k++) begin
      check("drain_pr0", fl_pr0, 32 + 2*k);
      check("drain_pr1", fl_pr1, 33 + 2*k);
      id_dispatch_num = 2'd2;
      tick();
    end
    id_dispatch_num = 2'd0;
    check("empty_count", fl_count, 0);
    check("empty_avail", fl_avail_num, 0);

    // Underflow: request from an empty list.
    id_dispatch_num = 2'd2;
    tick();
    id_dispatch_num = 2'd0;
    check("uflow_err",   fl_error, 1);
    check("uflow_count", fl_count, 0);
    check("uflow_head",  fl_pr0, 32);
    tick();
    check("uflow_err_pulse", fl_error, 0);

    // Retire two tags into the empty list.
    rob_retire_num   = 2'd2;
    rob_retire_told0 = 7'd5;
    rob_retire_told1 = 7'd9;
    tick();
    rob_retire_num = 2'd0;
    check("ret2_count", fl_count, 2);
    check("ret2_pr0",   fl_pr0, 5);
    check("ret2_pr1",   fl_pr1, 9);
    check("ret2_avail", fl_avail_num, 2);
    check("ret2_err",   fl_error, 0);

    // Bring count to 1, then over-request.
    id_dispatch_num = 2'd1;
    tick();
    check("one_count", fl_count, 1);
    check("one_pr0",   fl_pr0, 9);
    check("one_avail", fl_avail_num, 1);
    id_dispatch_num = 2'd2;
    tick();
    id_dispatch_num = 2'd0;
    check("clamp_count", fl_count, 0);
    check("clamp_err",   fl_error, 1);

    rob_retire_num   = 2'd1;
    rob_retire_told0 = 7'd11;
    tick();
    check("ret1_count", fl_count, 1);
    check("ret1_pr0",   fl_pr0, 11);
    check("ret1_err",   fl_error, 0);

    // Over-request at count 1 while retiring one tag in the same cycle.
    id_dispatch_num  = 2'd2;
    rob_retire_num   = 2'd1;
    rob_retire_told0 = 7'd13;
    tick();
    id_dispatch_num = 2'd0;
    rob_retire_num  = 2'd0;
    check("mix_count", fl_count, 1);
    check("mix_err",   fl_error, 1);
    check("mix_pr0",   fl_pr0, 13);

    // Flush recovery.
    do_reset();
    id_dispatch_num = 2'd2;
    tick();
    tick();
    tick();
    id_dispatch_num = 2'd0;
    check("pre_flush_count", fl_count, 26);
    check("pre_flush_pr0",   fl_pr0, 38);
    rob_retire_num   = 2'd2;
    rob_retire_told0 = 7'd3;
    rob_retire_told1 = 7'd4;
    tick();
    rob_retire_num = 2'd0;
    check("pre_flush_ret_count", fl_count, 28);
    rob_flush       = 1'b1;
    id_dispatch_num = 2'd2;
    tick();
    rob_flush       = 1'b0;
    id_dispatch_num = 2'd0;
    check("flush_count", fl_count, 32);
    check("flush_pr0",   fl_pr0, 34);
    check("flush_pr1",   fl_pr1, 35);
    check("flush_err",   fl_error, 0);
    for (int k = 0; k < 16; k++) begin
      check("post_flush_pr0", fl_pr0, flush_seq(2*k));
      check("post_flush_pr1", fl_pr1, flush_seq(2*k + 1));
      id_dispatch_num = 2'd2;
      tick();
    end
    id_dispatch_num = 2'd0;
    check("post_flush_count", fl_count, 0);

    // Steady state: dispatch 2 / retire 2 for 40 cycles, pointers wrap.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      e0 = (k < 16) ? 32 + 2*k : 2*(k - 16);
      check("wrap_pr0", fl_pr0, e0);
      check("wrap_pr1", fl_pr1, e0 + 1);
      id_dispatch_num  = 2'd2;
      rob_retire_num   = 2'd2;
      rob_retire_told0 = 7'(2*k);
      rob_retire_told1 = 7'(2*k + 1);
      tick();
      check("wrap_count", fl_count, 32);
      check("wrap_err",   fl_error, 0);
    end
    id_dispatch_num = 2'd0;
    rob_retire_num  = 2'd0;

    // Overflow: return two tags into a full list (head == tail == 16).
    rob_retire_num   = 2'd2;
    rob_retire_told0 = 7'd120;
    rob_retire_told1 = 7'd121;
    tick();
    rob_retire_num = 2'd0;
    check("oflow_err",   fl_error, 1);
    check("oflow_count", fl_count, 32);
    check("oflow_pr0",   fl_pr0, 48);
    check("oflow_pr1",   fl_pr1, 49);
    tick();
    check("oflow_err_pulse", fl_error, 0);

    // A request of 3 is clamped to 2 and flagged.
    id_dispatch_num = 2'd3;
    tick();
    id_dispatch_num = 2'd0;
    check("req3_err",   fl_error, 1);
    check("req3_count", fl_count, 30);
    check("req3_pr0",   fl_pr0, 50);
    check("req3_pr1",   fl_pr1, 51);

    // Reset wins over a simultaneous retire.
    rob_retire_num   = 2'd2;
    rob_retire_told0 = 7'd120;
    rob_retire_told1 = 7'd121;
    reset            = 1'b1;
    tick();
    reset          = 1'b0;
    rob_retire_num = 2'd0;
    check("rst2_pr0",   fl_pr0, 32);
    check("rst2_pr1",   fl_pr1, 33);
    check("rst2_count", fl_count, 32);
    check("rst2_avail", fl_avail_num, 2);
    check("rst2_err",   fl_error, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
